// File: rtl/bitonic_sort_frame_ctrl.sv
// Serialises a frame of N words into the sorter's parallel input, waits any time for the result, then streams it back out with labels.
// One frame in flight at a time: s_ready drops from issue until the last output beat; m_* hold while m_ready is low.
module bitonic_sort_frame_ctrl #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LABEL_WIDTH   = LOG_INPUT_NUM,
  localparam int N            = 1 << LOG_INPUT_NUM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [LABEL_WIDTH-1:0]     m_label,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [DATA_WIDTH*N-1:0]    sort_x,
  output logic [LABEL_WIDTH*N-1:0]   sort_x_label,
  output logic                       sort_x_valid,
  input  logic [DATA_WIDTH*N-1:0]    sort_y,
  input  logic [LABEL_WIDTH*N-1:0]   sort_y_label,
  input  logic                       sort_y_valid,
  output logic                       busy,
  output logic                       err
);

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, DRAIN} state_t;

  localparam logic [LOG_INPUT_NUM-1:0] LAST = LOG_INPUT_NUM'(N - 1);

  state_t                     state_q, state_d;
  logic [LOG_INPUT_NUM-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LOG_INPUT_NUM-1:0]   rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH*N-1:0]    sort_x_q, sort_x_d;
  logic [LABEL_WIDTH*N-1:0]   sort_x_label_q, sort_x_label_d;
  logic [DATA_WIDTH*N-1:0]    out_dat_q, out_dat_d;
  logic [LABEL_WIDTH*N-1:0]   out_lbl_q, out_lbl_d;
  logic                       err_q, err_d;

  int wr_dat_idx, wr_lbl_idx, rd_dat_idx, rd_lbl_idx;

  always_comb begin
    wr_dat_idx = int'(wr_cnt_q) * DATA_WIDTH;
    wr_lbl_idx = int'(wr_cnt_q) * LABEL_WIDTH;
    rd_dat_idx = int'(rd_cnt_q) * DATA_WIDTH;
    rd_lbl_idx = int'(rd_cnt_q) * LABEL_WIDTH;
  end

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    sort_x_d       = sort_x_q;
    sort_x_label_d = sort_x_label_q;
    out_dat_d      = out_dat_q;
    out_lbl_d      = out_lbl_q;
    // A result outside WAIT is a sorter protocol violation; it is flagged but never captured.
    err_d          = err_q | (sort_y_valid && (state_q != WAIT));

    case (state_q)
      COLLECT: begin
        if (s_valid) begin
          sort_x_d[wr_dat_idx +: DATA_WIDTH]        = s_data;
          sort_x_label_d[wr_lbl_idx +: LABEL_WIDTH] = LABEL_WIDTH'(wr_cnt_q);
          wr_cnt_d                                  = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sort_y_valid) begin
          out_dat_d = sort_y;
          out_lbl_d = sort_y_label;
          rd_cnt_d  = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST) begin
            rd_cnt_d = '0;
            state_d  = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= COLLECT;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      sort_x_q       <= '0;
      sort_x_label_q <= '0;
      out_dat_q      <= '0;
      out_lbl_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      sort_x_q       <= sort_x_d;
      sort_x_label_q <= sort_x_label_d;
      out_dat_q      <= out_dat_d;
      out_lbl_q      <= out_lbl_d;
      err_q          <= err_d;
    end
  end

  // s_ready is gated by rst directly so it is low during reset and high in the first cycle after release.
  assign s_ready      = rst && (state_q == COLLECT);
  assign sort_x_valid = (state_q == ISSUE);
  assign sort_x       = sort_x_q;
  assign sort_x_label = sort_x_label_q;
  assign m_valid      = (state_q == DRAIN);
  assign m_last       = (state_q == DRAIN) && (rd_cnt_q == LAST);
  assign m_data       = out_dat_q[rd_dat_idx +: DATA_WIDTH];
  assign m_label      = out_lbl_q[rd_lbl_idx +: LABEL_WIDTH];
  assign busy         = (state_q != COLLECT);
  assign err          = err_q;

endmodule

// File: tb/tb_bitonic_sort_frame_ctrl.sv
// Bench for bitonic_sort_frame_ctrl with N=4: ascending sorter model of latency 3, rank-based expected output.
module tb_bitonic_sort_frame_ctrl;

  localparam int LG = 2;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 2;

  logic            clk, rst;
  logic [DW-1:0]   s_data;
  logic            s_valid, s_ready;
  logic [DW-1:0]   m_data;
  logic [LW-1:0]   m_label;
  logic            m_valid, m_ready, m_last;
  logic [DW*N-1:0] sort_x, sort_y;
  logic [LW*N-1:0] sort_x_label, sort_y_label;
  logic            sort_x_valid, sort_y_valid;
  logic            busy, err;

  int tests = 0;
  int fails = 0;

  bitonic_sort_frame_ctrl #(.LOG_INPUT_NUM(LG), .DATA_WIDTH(DW), .LABEL_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_label(m_label), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .sort_x(sort_x), .sort_x_label(sort_x_label), .sort_x_valid(sort_x_valid),
    .sort_y(sort_y), .sort_y_label(sort_y_label), .sort_y_valid(sort_y_valid),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sorter model: stable insertion sort of (data,label) pairs, result valid 3 cycles after issue.
  function automatic logic [39:0] model_sort(input logic [31:0] xd, input logic [7:0] xl);
    logic [7:0]  d [4];
    logic [1:0]  l [4];
    logic [7:0]  td;
    logic [1:0]  tl;
    logic [39:0] r;
    for (int i = 0; i < 4; i++) begin
      d[i] = xd[8*i +: 8];
      l[i] = xl[2*i +: 2];
    end
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0; j--)
        if (d[j-1] > d[j]) begin
          td = d[j-1]; d[j-1] = d[j]; d[j] = td;
          tl = l[j-1]; l[j-1] = l[j]; l[j] = tl;
        end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8]    = d[i];
      r[32+2*i +: 2] = l[i];
    end
    return r;
  endfunction

  logic [2:0]  pipe;
  logic [39:0] y_q;
  logic        stray;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
      y_q  <= '0;
    end else begin
      pipe <= {pipe[1:0], sort_x_valid};
      if (sort_x_valid) y_q <= model_sort(sort_x, sort_x_label);
    end
  end

  assign sort_y       = y_q[31:0];
  assign sort_y_label = y_q[39:32];
  assign sort_y_valid = pipe[2] | stray;

  // Expected output by rank: element i lands at (#smaller) + (#equal with lower index).
  function automatic logic [39:0] exp_sort(input logic [31:0] d);
    logic [39:0] e;
    int r;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      r = 0;
      for (int j = 0; j < 4; j++)
        if ((d[8*j +: 8] < d[8*i +: 8]) || ((d[8*j +: 8] == d[8*i +: 8]) && (j < i))) r++;
      e[8*r +: 8]    = d[8*i +: 8];
      e[32+2*r +: 2] = 2'(i);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        @(negedge clk);
        s_valid = 1'b0;
        chk("no_early_issue", sort_x_valid, 0);
      end
      @(negedge clk);
      chk("s_ready_collect", s_ready, 1);
      chk("no_early_issue", sort_x_valid, 0);
      chk("not_busy_collect", busy, 0);
      s_valid = 1'b1;
      s_data  = d[8*i +: 8];
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("issue_pulse", sort_x_valid, 1);
    chk("sort_x", sort_x, d);
    chk("sort_x_label", sort_x_label, 8'he4);
    chk("busy_issue", busy, 1);
    chk("s_ready_issue", s_ready, 0);
    @(negedge clk);
    chk("issue_one_cycle", sort_x_valid, 0);
    chk("sort_x_hold", sort_x, d);
  endtask

  task automatic drain(input logic [31:0] d, input int stall_at, input int stall_len, input int nbeats);
    logic [39:0] e;
    int beat, cyc, st;
    e = exp_sort(d);
    beat = 0; cyc = 0; st = 0;
    while (beat < nbeats && cyc < 100) begin
      @(negedge clk);
      cyc++;
      m_ready = !(m_valid && beat == stall_at && st < stall_len);
      if (!m_ready) st++;
      chk("s_ready_busy", s_ready, 0);
      chk("busy", busy, 1);
      if (m_valid) begin
        chk("m_data", m_data, e[8*beat +: 8]);
        chk("m_label", m_label, e[32+2*beat +: 2]);
        chk("m_last", m_last, beat == 3);
        if (m_ready) beat++;
      end
    end
    chk("drain_beats", beat, nbeats);
    if (nbeats == 4) begin
      @(negedge clk);
      chk("m_valid_after_last", m_valid, 0);
      chk("busy_after_last", busy, 0);
      chk("s_ready_after_last", s_ready, 1);
    end
  endtask

  function automatic logic [31:0] rand_frame(input int maxv);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'($urandom_range(0, maxv));
    return d;
  endfunction

  logic [31:0] fr;

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_issue", sort_x_valid, 0);
    chk("rst_sort_x", sort_x, 0);
    chk("rst_sort_x_label", sort_x_label, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_label", m_label, 0);
    rst = 1'b1;
    #1 chk("s_ready_after_release", s_ready, 1);

    // 9,3,7,1 back-to-back, then with input gaps
    fr = {8'd1, 8'd7, 8'd3, 8'd9};
    chk("ref_basic", exp_sort(fr), {2'd0, 2'd2, 2'd1, 2'd3, 8'd9, 8'd7, 8'd3, 8'd1});
    send_frame(fr, 1'b0);
    drain(fr, 9, 0, 4);
    send_frame(fr, 1'b1);
    drain(fr, 9, 0, 4);

    // output backpressure mid-drain
    fr = rand_frame(255);
    send_frame(fr, 1'b0);
    drain(fr, 2, 5, 4);

    // stray result during COLLECT
    chk("err_clear", err, 0);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("err_set", err, 1);
    fr = rand_frame(255);
    send_frame(fr, 1'b0);
    drain(fr, 1, 2, 4);
    chk("err_sticky", err, 1);

    // reset after two output beats
    fr = rand_frame(255);
    send_frame(fr, 1'b0);
    drain(fr, 9, 0, 2);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_err", err, 0);
    chk("abort_m_data", m_data, 0);
    chk("abort_sort_x", sort_x, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_release_ready", s_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_m_valid", m_valid, 0);
    end
    fr = {8'd2, 8'd2, 8'd4, 8'd4};
    send_frame(fr, 1'b0);
    drain(fr, 9, 0, 4);

    // consecutive frames, random gaps/stalls, small values for ties
    for (int f = 0; f < 8; f++) begin
      fr = rand_frame(f < 3 ? 255 : 7);
      send_frame(fr, 1'($urandom_range(0, 1)));
      drain(fr, $urandom_range(1, 3), $urandom_range(0, 4), 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_frame_ctrl.md
BITONIC_SORT_FRAME_CTRL -- requirements
Module: bitonic_sort_frame_ctrl

Interface
REQ-001 SHALL have parameter LOG_INPUT_NUM, default 4, meaning log2 of the frame size N = 2**LOG_INPUT_NUM.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the element width.
REQ-003 SHALL have parameter LABEL_WIDTH, default LOG_INPUT_NUM, meaning the label width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  in  1  meaning reset: asynchronous, active-low.
REQ-006 SHALL have ports s_data  in  DATA_WIDTH, s_valid  in  1 and s_ready  out  1, meaning the serial input stream.
REQ-007 SHALL have ports m_data  out  DATA_WIDTH, m_label  out  LABEL_WIDTH, m_valid  out  1, m_ready  in  1 and m_last  out  1, meaning the serial output stream.
REQ-008 SHALL have ports sort_x  out  DATA_WIDTH*N, sort_x_label  out  LABEL_WIDTH*N and sort_x_valid  out  1, meaning the drive to the sorter; slot i occupies bits [W*(i+1)-1 : W*i].
REQ-009 SHALL have ports sort_y  in  DATA_WIDTH*N, sort_y_label  in  LABEL_WIDTH*N and sort_y_valid  in  1, meaning the sorter result, with the same packing as REQ-008.
REQ-010 SHALL have ports busy  out  1 and err  out  1, meaning busy = state != COLLECT, and err = sticky protocol error.

Function
REQ-011 SHALL implement FSM states COLLECT, ISSUE, WAIT and DRAIN.
REQ-012 In COLLECT, SHALL drive s_ready=1; on s_valid&s_ready, SHALL write s_data into sort_x slot wr_cnt, write the label into slot wr_cnt as wr_cnt zero-extended or truncated to LABEL_WIDTH, and increment wr_cnt.
REQ-013 In COLLECT, an accept with wr_cnt=N-1 SHALL move the FSM to ISSUE and clear wr_cnt to 0.
REQ-014 In ISSUE, SHALL assert sort_x_valid for exactly one cycle, then move to WAIT; s_ready SHALL be 0 in every state other than COLLECT.
REQ-015 SHALL hold sort_x and sort_x_label stable from ISSUE until the next COLLECT accept.
REQ-016 In WAIT, on sort_y_valid=1, SHALL capture sort_y and sort_y_label into an output buffer, clear rd_cnt, and move to DRAIN; the sorter latency is unbounded from the controller's view.
REQ-017 In DRAIN, SHALL drive m_valid=1, m_data = buffer slot rd_cnt, m_label = label slot rd_cnt, and m_last=1 when rd_cnt=N-1.
REQ-018 In DRAIN, on m_valid&m_ready SHALL advance rd_cnt; the transfer at rd_cnt=N-1 SHALL return the FSM to COLLECT, with m_valid=0 on the next cycle.
REQ-019 With m_ready=0, m_data, m_label and m_last SHALL hold stable.
REQ-020 sort_y_valid seen in any state other than WAIT SHALL be ignored for data and SHALL set err=1; err SHALL clear only on reset.
REQ-021 The controller SHALL process one frame at a time: the next frame is not accepted until DRAIN completes.
REQ-022 Throughput SHALL be at best N + 1 + L + N cycles per frame, where L is the sorter latency.

Reset
REQ-023 While rst=0, SHALL force state=COLLECT, wr_cnt=0, rd_cnt=0, sort_x_valid=0, m_valid=0, m_last=0, err=0 and busy=0.
REQ-024 While rst=0, SHALL drive s_ready=0; after release, s_ready SHALL be 1 in the first cycle.
REQ-025 While rst=0, SHALL clear the data buffers sort_x, sort_x_label, m_data and m_label to 0.
REQ-026 Reset asserted in any state SHALL abort the frame in progress; any partial frame SHALL be discarded and no m_valid SHALL follow.

Verification (LOG_INPUT_NUM=2, N=4, DATA_WIDTH=8; sorter model ascending, latency 3)
REQ-027 Basic frame: s_data 9,3,7,1 back-to-back with m_ready=1 -> one sort_x_valid pulse, then m_data 1,3,7,9, m_label 3,1,2,0, and m_last only on the 4th beat.
REQ-028 Input gaps: s_valid toggling 1,0,1,0... -> same output as REQ-027; sort_x_valid fires only after the 4th accepted word.
REQ-029 Output backpressure: m_ready=0 for 5 cycles mid-drain -> m_data held; no beat lost or duplicated; s_ready=0 throughout.
REQ-030 Stray result: sort_y_valid pulsed during COLLECT -> err=1 and sticky; the next frame still sorts correctly.
REQ-031 Reset mid-operation: rst=0 during DRAIN after 2 beats -> m_valid=0 immediately, state=COLLECT, and a fresh frame 4,4,2,2 yields 2,2,4,4.
REQ-032 Back-to-back frames: 3 consecutive frames -> each is output in sorted order, with busy=1 from ISSUE to the final m_last transfer.
